// File: rtl/op_lut_port_tagger.sv
// rtl/op_lut_port_tagger.sv - tags the first beat of each packet with its one-hot output port in tuser[31:24]
// Optional per-direction packet counters are built when OP_LUT_TAGGER_STATS_EN is defined.
module op_lut_port_tagger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 8,
    parameter int IN_FIFO_DEPTH_BITS   = 3
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    input  logic                                 hdr_vld,
    input  logic                                 is_from_cpu,
    input  logic [NUM_QUEUES-1:0]                to_cpu_port,
    input  logic [NUM_QUEUES-1:0]                from_cpu_port,
    output logic                                 rd_hdr_parser
`ifdef OP_LUT_TAGGER_STATS_EN
    ,
    output logic [31:0]                          pkt_from_cpu_cnt,
    output logic [31:0]                          pkt_to_cpu_cnt
`endif
);

    localparam int DEPTH   = 1 << IN_FIFO_DEPTH_BITS;
    localparam int KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int ENTRY_W = C_S_AXIS_DATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;
    localparam int CNT_W   = IN_FIFO_DEPTH_BITS + 1;

    typedef enum logic {WAIT_HDR = 1'b0, SEND_BODY = 1'b1} state_t;

    logic [ENTRY_W-1:0]            mem_q [DEPTH];
    logic [IN_FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          rdy_en_q;
    state_t                        state_q, state_d;

    logic                              push, pop, empty;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    head_tdata;
    logic [KEEP_W-1:0]                 head_tkeep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   head_tuser;
    logic                              head_tlast;

    // Two slots of headroom keep ready a registered decision that never overflows.
    assign s_axis_tready = rdy_en_q && (count_q <= CNT_W'(DEPTH - 2));
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign empty         = (count_q == '0);

    assign {head_tdata, head_tkeep, head_tuser, head_tlast} = mem_q[rd_ptr_q];

    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q <= WAIT_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_HDR:  if (pop && !head_tlast) state_d = SEND_BODY;
            SEND_BODY: if (pop && head_tlast)  state_d = WAIT_HDR;
            default:   state_d = WAIT_HDR;
        endcase
    end

    always_comb begin
        m_axis_tdata  = head_tdata;
        m_axis_tkeep  = head_tkeep;
        m_axis_tuser  = head_tuser;
        m_axis_tlast  = head_tlast;
        m_axis_tvalid = 1'b0;
        rd_hdr_parser = 1'b0;
        case (state_q)
            WAIT_HDR: begin
                m_axis_tvalid = !empty && hdr_vld;
                m_axis_tuser[24 +: NUM_QUEUES] = is_from_cpu ? from_cpu_port : to_cpu_port;
                rd_hdr_parser = !empty && hdr_vld && m_axis_tready;
            end
            SEND_BODY: begin
                m_axis_tvalid = !empty;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

`ifdef OP_LUT_TAGGER_STATS_EN
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pkt_from_cpu_cnt <= '0;
            pkt_to_cpu_cnt   <= '0;
        end else if (rd_hdr_parser) begin
            if (is_from_cpu) pkt_from_cpu_cnt <= pkt_from_cpu_cnt + 32'd1;
            else             pkt_to_cpu_cnt   <= pkt_to_cpu_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_op_lut_port_tagger.sv
// tb/tb_op_lut_port_tagger.sv - randomized self-checking bench for op_lut_port_tagger against a packet-level model
module tb_op_lut_port_tagger;

    localparam int DW    = 256;
    localparam int KW    = DW / 8;
    localparam int UW    = 128;
    localparam int NQ    = 8;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    typedef struct {
        logic          fc;
        logic [NQ-1:0] to_p;
        logic [NQ-1:0] from_p;
    } hdr_t;

    logic          axi_aclk = 1'b0;
    logic          axi_resetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic          hdr_vld = 1'b0;
    logic          is_from_cpu = 1'b0;
    logic [NQ-1:0] to_cpu_port = '0;
    logic [NQ-1:0] from_cpu_port = '0;
    logic          rd_hdr_parser;
`ifdef OP_LUT_TAGGER_STATS_EN
    logic [31:0]   pkt_from_cpu_cnt;
    logic [31:0]   pkt_to_cpu_cnt;
`endif

    op_lut_port_tagger #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .NUM_QUEUES          (NQ),
        .IN_FIFO_DEPTH_BITS  (3)
    ) dut (
        .axi_aclk        (axi_aclk),
        .axi_resetn      (axi_resetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .hdr_vld         (hdr_vld),
        .is_from_cpu     (is_from_cpu),
        .to_cpu_port     (to_cpu_port),
        .from_cpu_port   (from_cpu_port),
        .rd_hdr_parser   (rd_hdr_parser)
`ifdef OP_LUT_TAGGER_STATS_EN
        ,
        .pkt_from_cpu_cnt(pkt_from_cpu_cnt),
        .pkt_to_cpu_cnt  (pkt_to_cpu_cnt)
`endif
    );

    always #5 axi_aclk = ~axi_aclk;

    beat_t src_q[$];
    beat_t exp_q[$];
    hdr_t  hdr_q[$];
    int    fifo_cnt = 0;
    bit    mid_pkt  = 0;
    bit    ready_en = 0;
    bit    hdr_en   = 1;
    int    out_beats = 0;
    int    from_cnt = 0;
    int    to_cnt   = 0;
    int    n_asserts = 0;
    int    n_fails   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int len, input logic fc, input logic [NQ-1:0] port, input logic [7:0] src_byte);
        hdr_t  h;
        beat_t b;
        beat_t e;
        h.fc     = fc;
        h.to_p   = fc ? NQ'($urandom) : port;
        h.from_p = fc ? port : NQ'($urandom);
        hdr_q.push_back(h);
        for (int i = 0; i < len; i++) begin
            b.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b.k = $urandom;
            b.u = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) b.u[23:16] = src_byte;
            b.l = (i == len - 1);
            src_q.push_back(b);
            e = b;
            if (i == 0) e.u[31:24] = port;
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive at the falling edge, check settled outputs, then advance the model.
    task automatic step(input int p_src, input int p_dst);
        bit exp_srdy;
        bit exp_mvld;
        bit hs_out;
        bit push;
        @(negedge axi_aclk);
        s_axis_tvalid = (src_q.size() > 0) && ($urandom_range(99) < p_src);
        if (src_q.size() > 0) begin
            s_axis_tdata = src_q[0].d;
            s_axis_tkeep = src_q[0].k;
            s_axis_tuser = src_q[0].u;
            s_axis_tlast = src_q[0].l;
        end
        m_axis_tready = ($urandom_range(99) < p_dst);
        hdr_vld       = hdr_en && (hdr_q.size() > 0);
        if (hdr_q.size() > 0) begin
            is_from_cpu   = hdr_q[0].fc;
            to_cpu_port   = hdr_q[0].to_p;
            from_cpu_port = hdr_q[0].from_p;
        end else begin
            is_from_cpu   = 1'($urandom);
            to_cpu_port   = NQ'($urandom);
            from_cpu_port = NQ'($urandom);
        end
        #1;
        exp_srdy = ready_en && (fifo_cnt <= DEPTH - 2);
        exp_mvld = (fifo_cnt > 0) && (mid_pkt || hdr_vld);
        hs_out   = exp_mvld && m_axis_tready;
        chk("s_tready", s_axis_tready, exp_srdy);
        chk("m_tvalid", m_axis_tvalid, exp_mvld);
        chk("rd_hdr", rd_hdr_parser, hs_out && !mid_pkt);
        if (hs_out && exp_q.size() > 0) begin
            chk("tdata", m_axis_tdata, exp_q[0].d);
            chk("tkeep", m_axis_tkeep, exp_q[0].k);
            chk("tuser", m_axis_tuser, exp_q[0].u);
            chk("tlast", m_axis_tlast, exp_q[0].l);
        end
        push = s_axis_tvalid && exp_srdy;
        if (push) begin
            void'(src_q.pop_front());
            fifo_cnt++;
        end
        if (hs_out && exp_q.size() > 0) begin
            if (!mid_pkt && hdr_q.size() > 0) begin
                if (hdr_q[0].fc) from_cnt++;
                else             to_cnt++;
                void'(hdr_q.pop_front());
            end
            mid_pkt = !exp_q[0].l;
            void'(exp_q.pop_front());
            fifo_cnt--;
            out_beats++;
        end
        ready_en = 1;
    endtask

    task automatic drain(input int p_src, input int p_dst);
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) step(p_src, p_dst);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge axi_aclk);
        axi_resetn    = 1'b0;
        s_axis_tvalid = 1'b0;
        hdr_vld       = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_rd_hdr", rd_hdr_parser, 1'b0);
        src_q.delete();
        exp_q.delete();
        hdr_q.delete();
        fifo_cnt = 0;
        mid_pkt  = 0;
        ready_en = 0;
        from_cnt = 0;
        to_cnt   = 0;
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        #1;
        chk("rel_s_tready", s_axis_tready, 1'b0);
        ready_en = 1;
    endtask

    initial begin
        do_reset();

        // 1-beat to-CPU packet
        add_pkt(1, 1'b0, 8'h02, 8'h01);
        drain(100, 100);

        // 4-beat from-CPU packet, body untouched
        add_pkt(4, 1'b1, 8'h04, NQ'($urandom));
        drain(100, 100);

        // header held back while the first beat waits at the FIFO head
        hdr_en = 0;
        add_pkt(1, 1'b0, 8'h20, 8'h33);
        for (int i = 0; i < 6; i++) step(100, 100);
        hdr_en = 1;
        drain(100, 100);

        // sink stalled for 10 cycles while the source keeps sending
        for (int p = 0; p < 3; p++) add_pkt(4, p[0], NQ'(1 << p), 8'h10);
        for (int i = 0; i < 10; i++) step(100, 0);
        chk("stall_fifo_full", s_axis_tready, 1'b0);
        drain(100, 100);

        // randomized traffic with random back-pressure on both sides
        for (int p = 0; p < 40; p++)
            add_pkt($urandom_range(1, 6), 1'($urandom), NQ'(1 << $urandom_range(0, NQ - 1)), 8'($urandom));
        drain(70, 60);

        // reset in the middle of a 5-beat packet
        add_pkt(5, 1'b0, 8'h08, 8'h55);
        add_pkt(3, 1'b1, 8'h40, 8'h66);
        out_beats = 0;
        for (int i = 0; i < 50 && out_beats < 2; i++) step(100, 100);
        chk("pre_reset_beats", out_beats, 2);
        do_reset();
        add_pkt(2, 1'b1, 8'h10, 8'h77);
        drain(100, 100);

        // 3 from-CPU and 2 to-CPU packets for the counters
        do_reset();
        for (int p = 0; p < 5; p++) add_pkt(2, (p < 3), 8'h80, 8'h01);
        drain(80, 80);
`ifdef OP_LUT_TAGGER_STATS_EN
        chk("from_cnt", pkt_from_cpu_cnt, 3);
        chk("to_cnt", pkt_to_cpu_cnt, 2);
`endif
        chk("model_from_cnt", from_cnt, 3);
        chk("model_to_cnt", to_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
